vending_controller: RTL and testbench
=====================================

// Module: vending_controller
// PURPOSE
//  Clocked, parametrised successor of the combinational vending checker. Accumulates coin credit,
//  checks a (tag, count) order against a per-item price table and stock counters, then dispenses.
//  Returns change on vend, on cancel or on inactivity timeout; supports per-item refill.
//  Sits between the coin acceptor / keypad front end and the dispenser / change-hopper drivers.
// PARAMETERS
//  TAG_W      2                   item select width; NUM_ITEMS = 2**TAG_W
//  COUNT_W    3                   order quantity width (max 7 per order)
//  MONEY_W    8                   credit, coin and change width (unsigned)
//  STOCK_W    4                   per-item stock counter width
//  INIT_STOCK 15                  stock of every item after reset and after refill
//  PRICES     32'h0C_08_05_03     packed price table; item i at [i*MONEY_W +: MONEY_W] (3,5,8,12)
//  TIMEOUT    255                 idle cycles in COLLECT before automatic refund
// PORTS
//  clk           in   1                 single clock, rising edge
//  rst           in   1                 synchronous, active-high reset
//  coin_valid    in   1                 one coin presented this cycle
//  coin_value    in   MONEY_W           coin value
//  coin_reject   out  1                 1-cycle pulse: presented coin not accepted
//  sel_valid     in   1                 order request strobe
//  tag           in   TAG_W             item selected
//  count         in   COUNT_W           quantity requested
//  cancel        in   1                 refund request
//  refill_valid  in   1                 restock strobe
//  refill_tag    in   TAG_W             item to restock
//  credit        out  MONEY_W           current credit
//  possibility   out  1                 1-cycle pulse: order accepted (same cycle as vend_valid)
//  order_reject  out  1                 1-cycle pulse: order refused
//  vend_valid    out  1                 1-cycle dispense pulse
//  vend_tag      out  TAG_W             item dispensed (valid with vend_valid)
//  vend_count    out  COUNT_W           quantity dispensed (valid with vend_valid)
//  change_valid  out  1                 1-cycle change pulse
//  change_amount out  MONEY_W           refund/change value (valid with change_valid)
//  stock_empty   out  NUM_ITEMS         bit i = 1 when stock[i] == 0
// BEHAVIOUR
//  Reset: state=IDLE; credit=0; all pulses 0; vend_*/change_amount=0; stock[i]=INIT_STOCK; timer=0.
//   Reset mid-operation discards credit; no change pulse is issued. All outputs registered.
//  FSM IDLE -> COLLECT -> CHECK -> VEND -> CHANGE -> IDLE.
//  IDLE: coin_valid -> credit=coin_value, go COLLECT. sel_valid/cancel ignored.
//  COLLECT:
//   - coin: credit += coin_value if sum < 2**MONEY_W, else coin_reject=1 and credit unchanged.
//   - priority: cancel > sel_valid. cancel -> CHANGE. sel_valid -> latch tag/count, go CHECK.
//   - coin and sel_valid in the same cycle: coin is added first; CHECK uses the updated credit.
//   - timer clears on any accepted coin or sel_valid; timer reaching TIMEOUT -> CHANGE.
//  CHECK (1 cycle): cost = PRICES[tag]*count, computed at MONEY_W+COUNT_W bits with no truncation.
//   ok = count!=0 && stock[tag]>=count && cost<=credit.
//   ok -> VEND; else order_reject=1, return to COLLECT with credit kept and timer cleared.
//  VEND (1 cycle): vend_valid=possibility=1, vend_tag/count=latched values; stock[tag]-=count;
//   credit-=cost -> CHANGE.
//  CHANGE (1 cycle): if credit!=0, change_valid=1 and change_amount=credit; credit=0 -> IDLE.
//  Coins in CHECK/VEND/CHANGE: coin_reject=1, credit untouched.
//  Latency: sel_valid @t -> CHECK @t+1 -> vend_valid @t+2 -> change_valid @t+3.
//  Refill (any state, rst excepted): stock[refill_tag]=INIT_STOCK next cycle.
//   Refill and VEND on the same tag in the same cycle: refill wins.
//  stock_empty is combinational from the stock registers.
// TESTING
//  1 coins 5,5; sel tag=1 cnt=1 -> vend_valid/possibility @+2 (tag1, cnt1), change 5 @+3,
//    stock[1] 15->14.
//  2 credit 10; sel tag=3 cnt=1 (price 12) -> order_reject, credit stays 10;
//    cancel -> change_amount=10, credit 0.
//  3 tag0 cnt7 twice with credit 21 each -> stock[0]=1; cnt2 -> reject;
//    refill tag0 -> stock 15, cnt2 accepted; cnt0 -> reject.
//  4 credit 250 + coin 10 -> coin_reject, credit 250; coin in VEND -> coin_reject.
//  5 coin 3 then 255 idle cycles -> change_valid, change_amount=3, state IDLE.
//  6 rst asserted in VEND -> next cycle credit 0, no vend/change pulse, all stock 15;
//    refill colliding with vend on same tag -> stock 15.

Source files
------------

// File: rtl/vending_controller.sv
// Vending controller: accumulates coin credit, checks an order against prices and stock,
// dispenses, and returns change on vend, cancel or inactivity timeout.
module vending_controller #(
  parameter int TAG_W      = 2,
  parameter int COUNT_W    = 3,
  parameter int MONEY_W    = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 15,
  parameter logic [(2**TAG_W)*MONEY_W-1:0] PRICES = 32'h0C_08_05_03,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  coin_valid,
  input  logic [MONEY_W-1:0]    coin_value,
  output logic                  coin_reject,
  input  logic                  sel_valid,
  input  logic [TAG_W-1:0]      tag,
  input  logic [COUNT_W-1:0]    count,
  input  logic                  cancel,
  input  logic                  refill_valid,
  input  logic [TAG_W-1:0]      refill_tag,
  output logic [MONEY_W-1:0]    credit,
  output logic                  possibility,
  output logic                  order_reject,
  output logic                  vend_valid,
  output logic [TAG_W-1:0]      vend_tag,
  output logic [COUNT_W-1:0]    vend_count,
  output logic                  change_valid,
  output logic [MONEY_W-1:0]    change_amount,
  output logic [2**TAG_W-1:0]   stock_empty
);

  localparam int NUM_ITEMS = 2**TAG_W;
  localparam int COST_W    = MONEY_W + COUNT_W;
  localparam int TIMER_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CHECK, S_VEND, S_CHANGE} state_t;

  state_t               state_q, state_d;
  logic [MONEY_W-1:0]   credit_q, credit_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic                 coin_reject_q, coin_reject_d;
  logic                 possibility_q, possibility_d;
  logic                 order_reject_q, order_reject_d;
  logic                 vend_valid_q, vend_valid_d;
  logic [TAG_W-1:0]     vend_tag_q, vend_tag_d;
  logic [COUNT_W-1:0]   vend_count_q, vend_count_d;
  logic                 change_valid_q, change_valid_d;
  logic [MONEY_W-1:0]   change_amount_q, change_amount_d;

  logic [MONEY_W:0]     coin_sum_s;
  logic [COST_W-1:0]    cost_s;
  logic [TIMER_W-1:0]   timer_inc_s;
  logic                 order_ok_s;
  logic                 coin_ok_s;
  logic [MONEY_W-1:0]   credit_acc_s;

  function automatic logic [MONEY_W-1:0] price_of(input logic [TAG_W-1:0] t);
    return PRICES[t*MONEY_W +: MONEY_W];
  endfunction

  // Cost is kept at full width so an oversized order can never alias to a cheap one.
  assign coin_sum_s  = {1'b0, credit_q} + {1'b0, coin_value};
  assign cost_s      = COST_W'(price_of(tag_q)) * COST_W'(count_q);
  assign timer_inc_s = timer_q + TIMER_W'(1);
  assign order_ok_s  = (count_q != COUNT_W'(0)) && (32'(stock_q[tag_q]) >= 32'(count_q)) &&
                       (cost_s <= COST_W'(credit_q));

  // Next-state, credit, timer and output-pulse logic.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    timer_d         = timer_q;
    tag_d           = tag_q;
    count_d         = count_q;
    coin_reject_d   = 1'b0;
    possibility_d   = 1'b0;
    order_reject_d  = 1'b0;
    vend_valid_d    = 1'b0;
    vend_tag_d      = vend_tag_q;
    vend_count_d    = vend_count_q;
    change_valid_d  = 1'b0;
    change_amount_d = change_amount_q;
    coin_ok_s       = 1'b0;
    credit_acc_s    = credit_q;
    case (state_q)
      S_IDLE: begin
        if (coin_valid) begin
          credit_d = coin_value;
          timer_d  = TIMER_W'(0);
          state_d  = S_COLLECT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (coin_valid) begin
          if (!coin_sum_s[MONEY_W]) begin
            coin_ok_s    = 1'b1;
            credit_acc_s = coin_sum_s[MONEY_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          coin_ok_s = 1'b0;
        end
        credit_d = credit_acc_s;
        // A coin arriving with cancel or an order is counted before either is acted on.
        if (cancel) begin
          state_d         = S_CHANGE;
          change_valid_d  = (credit_acc_s != MONEY_W'(0));
          change_amount_d = credit_acc_s;
        end else if (sel_valid) begin
          state_d = S_CHECK;
          tag_d   = tag;
          count_d = count;
          timer_d = TIMER_W'(0);
        end else if (coin_ok_s) begin
          timer_d = TIMER_W'(0);
        end else if (timer_inc_s == TIMER_W'(TIMEOUT)) begin
          state_d         = S_CHANGE;
          change_valid_d  = (credit_acc_s != MONEY_W'(0));
          change_amount_d = credit_acc_s;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      S_CHECK: begin
        coin_reject_d = coin_valid;
        if (order_ok_s) begin
          state_d       = S_VEND;
          vend_valid_d  = 1'b1;
          possibility_d = 1'b1;
          vend_tag_d    = tag_q;
          vend_count_d  = count_q;
        end else begin
          state_d        = S_COLLECT;
          order_reject_d = 1'b1;
          timer_d        = TIMER_W'(0);
        end
      end
      S_VEND: begin
        coin_reject_d   = coin_valid;
        credit_d        = credit_q - cost_s[MONEY_W-1:0];
        change_valid_d  = (credit_d != MONEY_W'(0));
        change_amount_d = credit_d;
        state_d         = S_CHANGE;
      end
      S_CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = MONEY_W'(0);
        state_d       = S_IDLE;
      end
      default: begin
        credit_d = MONEY_W'(0);
        state_d  = S_IDLE;
      end
    endcase
  end

  // Per-item stock update; a refill overrides a dispense on the same item.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (refill_valid && (refill_tag == TAG_W'(i))) begin
        stock_d[i] = STOCK_W'(INIT_STOCK);
      end else if ((state_q == S_VEND) && (tag_q == TAG_W'(i))) begin
        stock_d[i] = stock_q[i] - STOCK_W'(count_q);
      end else begin
        stock_d[i] = stock_q[i];
      end
    end
  end

  // Empty flags are decoded straight from the stock registers.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_empty[i] = (stock_q[i] == STOCK_W'(0));
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      credit_q        <= MONEY_W'(0);
      timer_q         <= TIMER_W'(0);
      tag_q           <= TAG_W'(0);
      count_q         <= COUNT_W'(0);
      coin_reject_q   <= 1'b0;
      possibility_q   <= 1'b0;
      order_reject_q  <= 1'b0;
      vend_valid_q    <= 1'b0;
      vend_tag_q      <= TAG_W'(0);
      vend_count_q    <= COUNT_W'(0);
      change_valid_q  <= 1'b0;
      change_amount_q <= MONEY_W'(0);
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      timer_q         <= timer_d;
      tag_q           <= tag_d;
      count_q         <= count_d;
      coin_reject_q   <= coin_reject_d;
      possibility_q   <= possibility_d;
      order_reject_q  <= order_reject_d;
      vend_valid_q    <= vend_valid_d;
      vend_tag_q      <= vend_tag_d;
      vend_count_q    <= vend_count_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign credit        = credit_q;
  assign coin_reject   = coin_reject_q;
  assign possibility   = possibility_q;
  assign order_reject  = order_reject_q;
  assign vend_valid    = vend_valid_q;
  assign vend_tag      = vend_tag_q;
  assign vend_count    = vend_count_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios followed by random
// transactions, all predicted by a transaction-level model of credit and stock.
module tb_vending_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = 8'd0;
  logic       coin_reject;
  logic       sel_valid = 1'b0;
  logic [1:0] tag = 2'd0;
  logic [2:0] count = 3'd0;
  logic       cancel = 1'b0;
  logic       refill_valid = 1'b0;
  logic [1:0] refill_tag = 2'd0;
  logic [7:0] credit;
  logic       possibility;
  logic       order_reject;
  logic       vend_valid;
  logic [1:0] vend_tag;
  logic [2:0] vend_count;
  logic       change_valid;
  logic [7:0] change_amount;
  logic [3:0] stock_empty;

  vending_controller dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
    .sel_valid(sel_valid), .tag(tag), .count(count), .cancel(cancel),
    .refill_valid(refill_valid), .refill_tag(refill_tag),
    .credit(credit), .possibility(possibility), .order_reject(order_reject),
    .vend_valid(vend_valid), .vend_tag(vend_tag), .vend_count(vend_count),
    .change_valid(change_valid), .change_amount(change_amount), .stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int credit_m = 0;
  bit active_m = 1'b0;
  int stock_m [4] = '{15, 15, 15, 15};
  int price_m [4] = '{3, 5, 8, 12};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic logic [3:0] empty_m();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (stock_m[i] == 0);
    return e;
  endfunction

  task automatic insert_coin(input int v);
    bit rej;
    coin_valid = 1'b1;
    coin_value = 8'(v);
    tick();
    coin_valid = 1'b0;
    rej = 1'b0;
    if (!active_m) begin
      credit_m = v;
      active_m = 1'b1;
    end else if (credit_m + v > 255) begin
      rej = 1'b1;
    end else begin
      credit_m = credit_m + v;
    end
    chk("coin_reject", coin_reject, rej);
    chk("coin_credit", credit, credit_m);
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_change_valid", change_valid, credit_m != 0);
    if (credit_m != 0) chk("cancel_change_amount", change_amount, credit_m);
    tick();
    chk("cancel_credit_zero", credit, 0);
    credit_m = 0;
    active_m = 1'b0;
  endtask

  task automatic do_refill(input int t);
    refill_valid = 1'b1;
    refill_tag = 2'(t);
    tick();
    refill_valid = 1'b0;
    stock_m[t] = 15;
    chk("refill_stock_empty", stock_empty, empty_m());
    chk("refill_credit", credit, credit_m);
  endtask

  task automatic do_order(input int t, input int c, input bit coin_in_vend,
                          input bit refill_in_vend, input int rt);
    int cost;
    int rem;
    bit ok;
    cost = price_m[t] * c;
    ok = (c != 0) && (stock_m[t] >= c) && (cost <= credit_m);
    sel_valid = 1'b1;
    tag = 2'(t);
    count = 3'(c);
    tick();
    sel_valid = 1'b0;
    chk("check_cycle_vend", vend_valid, 0);
    chk("check_cycle_reject", order_reject, 0);
    tick();
    if (ok) begin
      chk("vend_valid", vend_valid, 1);
      chk("possibility", possibility, 1);
      chk("vend_tag", vend_tag, t);
      chk("vend_count", vend_count, c);
      chk("vend_no_reject", order_reject, 0);
      if (coin_in_vend) begin
        coin_valid = 1'b1;
        coin_value = 8'd7;
      end
      if (refill_in_vend) begin
        refill_valid = 1'b1;
        refill_tag = 2'(rt);
      end
      tick();
      coin_valid = 1'b0;
      refill_valid = 1'b0;
      rem = credit_m - cost;
      chk("change_valid", change_valid, rem != 0);
      if (rem != 0) chk("change_amount", change_amount, rem);
      chk("change_credit", credit, rem);
      chk("vend_pulse_ends", vend_valid, 0);
      if (coin_in_vend) chk("coin_in_vend_reject", coin_reject, 1);
      stock_m[t] = stock_m[t] - c;
      if (refill_in_vend) stock_m[rt] = 15;
      tick();
      chk("post_change_credit", credit, 0);
      chk("change_pulse_ends", change_valid, 0);
      credit_m = 0;
      active_m = 1'b0;
    end else begin
      chk("order_reject", order_reject, 1);
      chk("reject_no_vend", vend_valid, 0);
      chk("reject_no_possibility", possibility, 0);
      chk("reject_credit_kept", credit, credit_m);
    end
    chk("order_stock_empty", stock_empty, empty_m());
  endtask

  initial begin
    int early;
    int r;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_credit", credit, 0);
    chk("rst_vend_valid", vend_valid, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_coin_reject", coin_reject, 0);
    chk("rst_order_reject", order_reject, 0);
    chk("rst_vend_tag", vend_tag, 0);
    chk("rst_change_amount", change_amount, 0);
    chk("rst_stock_empty", stock_empty, 0);

    // Orders in IDLE are ignored.
    sel_valid = 1'b1;
    tag = 2'd0;
    count = 3'd1;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("idle_sel_no_vend", vend_valid, 0);
    chk("idle_sel_no_reject", order_reject, 0);

    // Scenario 1: plain purchase with change.
    insert_coin(5);
    insert_coin(5);
    do_order(1, 1, 1'b0, 1'b0, 0);

    // Scenario 2: unaffordable order, then cancel.
    insert_coin(5);
    insert_coin(5);
    do_order(3, 1, 1'b0, 1'b0, 0);
    do_cancel();

    // Scenario 3: drain item 0, stock-limited reject, refill, zero-count reject.
    insert_coin(10);
    insert_coin(11);
    do_order(0, 7, 1'b0, 1'b0, 0);
    insert_coin(21);
    do_order(0, 7, 1'b0, 1'b0, 0);
    insert_coin(6);
    do_order(0, 2, 1'b0, 1'b0, 0);
    do_refill(0);
    do_order(0, 2, 1'b0, 1'b0, 0);
    insert_coin(5);
    do_order(0, 0, 1'b0, 1'b0, 0);
    do_cancel();

    // Scenario 4: credit overflow and a coin offered during VEND.
    insert_coin(250);
    insert_coin(10);
    do_order(0, 1, 1'b1, 1'b0, 0);

    // Scenario 5: inactivity timeout refund.
    insert_coin(3);
    early = 0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (change_valid) early++;
    end
    chk("timeout_no_early_change", early, 0);
    tick();
    chk("timeout_change_valid", change_valid, 1);
    chk("timeout_change_amount", change_amount, 3);
    tick();
    chk("timeout_credit_zero", credit, 0);
    credit_m = 0;
    active_m = 1'b0;
    sel_valid = 1'b1;
    tag = 2'd0;
    count = 3'd1;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("timeout_back_idle", vend_valid, 0);

    // Scenario 6: reset while in VEND, then refill colliding with vend.
    insert_coin(10);
    sel_valid = 1'b1;
    tag = 2'd2;
    count = 3'd1;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("pre_rst_vend_valid", vend_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_no_vend", vend_valid, 0);
    chk("mid_rst_no_change", change_valid, 0);
    chk("mid_rst_stock_empty", stock_empty, 0);
    credit_m = 0;
    active_m = 1'b0;
    for (int i = 0; i < 4; i++) stock_m[i] = 15;
    insert_coin(8);
    do_order(2, 1, 1'b0, 1'b1, 2);
    insert_coin(56);
    do_order(2, 7, 1'b0, 1'b0, 0);
    insert_coin(56);
    do_order(2, 7, 1'b0, 1'b0, 0);
    insert_coin(8);
    do_order(2, 1, 1'b0, 1'b0, 0);
    do_refill(2);

    // Random transactions against the model.
    for (int n = 0; n < 80; n++) begin
      if (!active_m) begin
        insert_coin(int'($urandom_range(0, 120)));
      end else begin
        r = int'($urandom_range(0, 9));
        if (r <= 3) begin
          insert_coin(int'($urandom_range(0, 255)));
        end else if (r <= 6) begin
          do_order(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'b0, 0);
        end else if (r == 7) begin
          do_cancel();
        end else begin
          do_refill(int'($urandom_range(0, 3)));
        end
      end
    end
    if (active_m) do_cancel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
